uart_pwm_frame_parser: RTL

- Sits between the UART byte receiver and the PWM/DAC channel register bank in the UART-controlled PWM top level.
- Assembles 14-byte command frames from received bytes: header 0x55, reg_func, ch, ctrl_sta, duty_num, dessert_h, dessert_l, pulse_num, pat1..pat4, crc, footer 0xAA.
- Checks the CRC-8 and the frame, then presents the decoded fields with a one-cycle write strobe.
- Rejected frames never change the field outputs.

---
 rtl/uart_pwm_pkg.sv | 19 +
 rtl/uart_pwm_frame_parser_crc8_byte.sv | 20 ++
 rtl/uart_pwm_frame_parser.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pwm_pkg.sv
// Shared constants and types for the UART-controlled PWM command path.
// Frame layout: header, 11 payload bytes, crc, footer.
package uart_pwm_pkg;

    localparam logic [7:0] FRAME_HDR   = 8'h55;
    localparam logic [7:0] FRAME_FTR   = 8'hAA;
    localparam logic [7:0] FUNC_CFG    = 8'h01;
    localparam logic [7:0] FUNC_EN     = 8'h02;
    localparam int         PAYLOAD_LEN = 11;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CRC,
        ST_FOOTER
    } frame_state_t;

endpackage

// File: rtl/uart_pwm_frame_parser_crc8_byte.sv
// One byte of CRC-8 (MSB-first, no reflection), fully combinational.
module crc8_byte
    import uart_pwm_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/uart_pwm_frame_parser.sv
// Assembles 14-byte command frames from the UART receiver, validates footer,
// CRC and function/channel, then presents decoded fields with a write strobe.
module uart_pwm_frame_parser
    import uart_pwm_pkg::*;
#(
    parameter int NUM_CHANNELS = 6,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int TIMEOUT_US   = 2000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        cfg_wr,
    output logic        en_wr,
    output logic [7:0]  ch,
    output logic [7:0]  ctrl_sta,
    output logic [7:0]  duty_num,
    output logic [15:0] pulse_dessert,
    output logic [7:0]  pulse_num,
    output logic [31:0] pattern,
    output logic        crc_err,
    output logic        frame_err,
    output logic        func_err,
    output logic        busy
);

    localparam int          TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam logic [31:0] TO_LIMIT    = 32'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  LAST_IDX    = 4'(PAYLOAD_LEN - 1);
    localparam logic [7:0]  CH_MAX      = 8'(NUM_CHANNELS);

    frame_state_t state, state_next;
    logic [3:0]   idx;
    logic [7:0]   crc;
    logic [7:0]   crc_nxt;
    logic [7:0]   rx_crc;
    logic [7:0]   shadow [PAYLOAD_LEN];
    logic [31:0]  to_cnt;

    logic timeout_hit;
    logic ftr_bad, crc_bad, func_bad, accept;
    logic func_ok, ch_ok;

    crc8_byte u_crc (
        .crc_in  (crc),
        .data_in (rx_data),
        .crc_out (crc_nxt)
    );

    assign func_ok = (shadow[0] == FUNC_CFG) || (shadow[0] == FUNC_EN);
    assign ch_ok   = (shadow[1] != 8'h00) && (shadow[1] <= CH_MAX);
    assign busy    = (state != ST_IDLE);

    // A byte landing in the expiry cycle wins over the timeout.
    assign timeout_hit = (state != ST_IDLE) && !rx_done && (to_cnt >= TO_LIMIT);

    always_comb begin
        state_next = state;
        ftr_bad    = 1'b0;
        crc_bad    = 1'b0;
        func_bad   = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_done && rx_data == FRAME_HDR) state_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (rx_done && idx == LAST_IDX) state_next = ST_CRC;
            end
            ST_CRC: begin
                if (rx_done) state_next = ST_FOOTER;
            end
            ST_FOOTER: begin
                if (rx_done) begin
                    state_next = ST_IDLE;
                    if (rx_data != FRAME_FTR)    ftr_bad  = 1'b1;
                    else if (rx_crc != crc)      crc_bad  = 1'b1;
                    else if (!(func_ok && ch_ok)) func_bad = 1'b1;
                    else                          accept   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (timeout_hit) state_next = ST_IDLE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx           <= '0;
            crc           <= '0;
            rx_crc        <= '0;
            to_cnt        <= '0;
            for (int i = 0; i < PAYLOAD_LEN; i++) shadow[i] <= '0;
            cfg_wr        <= 1'b0;
            en_wr         <= 1'b0;
            crc_err       <= 1'b0;
            frame_err     <= 1'b0;
            func_err      <= 1'b0;
            ch            <= '0;
            ctrl_sta      <= '0;
            duty_num      <= '0;
            pulse_dessert <= '0;
            pulse_num     <= '0;
            pattern       <= '0;
        end else begin
            if (rx_done || timeout_hit) to_cnt <= '0;
            else if (state != ST_IDLE)  to_cnt <= to_cnt + 32'd1;

            if (rx_done) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == FRAME_HDR) begin
                            crc <= '0;
                            idx <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        shadow[idx] <= rx_data;
                        crc         <= crc_nxt;
                        idx         <= idx + 4'd1;
                    end
                    ST_CRC:  rx_crc <= rx_data;
                    default: ;
                endcase
            end

            frame_err <= ftr_bad | timeout_hit;
            crc_err   <= crc_bad;
            func_err  <= func_bad;
            cfg_wr    <= accept && (shadow[0] == FUNC_CFG);
            en_wr     <= accept && (shadow[0] == FUNC_EN);

            if (accept) begin
                ch            <= shadow[1];
                ctrl_sta      <= shadow[2];
                duty_num      <= shadow[3];
                pulse_dessert <= {shadow[4], shadow[5]};
                pulse_num     <= shadow[6];
                pattern       <= {shadow[7], shadow[8], shadow[9], shadow[10]};
            end
        end
    end

endmodule
